// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the 2x2 systolic array sequencer.
package systolic_ctrl_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 16;
    localparam int FEED_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_skew_feed.sv
// Maps the feed step and latched operands onto the diagonally skewed edge buses.
module systolic_skew_feed
    import systolic_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              active_i,
    input  logic [1:0]        cnt_i,
    input  logic [DATA_W-1:0] a00_i,
    input  logic [DATA_W-1:0] a01_i,
    input  logic [DATA_W-1:0] a10_i,
    input  logic [DATA_W-1:0] a11_i,
    input  logic [DATA_W-1:0] b00_i,
    input  logic [DATA_W-1:0] b01_i,
    input  logic [DATA_W-1:0] b10_i,
    input  logic [DATA_W-1:0] b11_i,
    output logic [DATA_W-1:0] a_row0_o,
    output logic [DATA_W-1:0] a_row1_o,
    output logic [DATA_W-1:0] b_col0_o,
    output logic [DATA_W-1:0] b_col1_o
);

    always_comb begin
        a_row0_o = '0;
        a_row1_o = '0;
        b_col0_o = '0;
        b_col1_o = '0;
        if (active_i) begin
            // row 1 and column 1 lag by one step so operands meet in the right PE
            case (cnt_i)
                2'd0: begin
                    a_row0_o = a00_i;
                    b_col0_o = b00_i;
                end
                2'd1: begin
                    a_row0_o = a01_i;
                    a_row1_o = a10_i;
                    b_col0_o = b10_i;
                    b_col1_o = b01_i;
                end
                2'd2: begin
                    a_row1_o = a11_i;
                    b_col1_o = b11_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the 2x2 output-stationary systolic array: accept, clear,
// skewed feed, drain, capture, hand off. Every output is a flop.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ACC_W        = DEF_ACC_W,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] b00,
    input  logic [DATA_W-1:0] b01,
    input  logic [DATA_W-1:0] b10,
    input  logic [DATA_W-1:0] b11,
    input  logic              abort,
    output logic              acc_clr,
    output logic              feed_valid,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic [DATA_W-1:0] b_col0,
    output logic [DATA_W-1:0] b_col1,
    input  logic [ACC_W-1:0]  acc00,
    input  logic [ACC_W-1:0]  acc01,
    input  logic [ACC_W-1:0]  acc10,
    input  logic [ACC_W-1:0]  acc11,
    output logic [ACC_W-1:0]  c00,
    output logic [ACC_W-1:0]  c01,
    output logic [ACC_W-1:0]  c10,
    output logic [ACC_W-1:0]  c11,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a job, operands latched on accept
    // CLEAR | one-cycle accumulator clear
    // FEED  | three skewed operand steps
    // DRAIN | pipeline settle, capture on the final cycle
    // DONE  | results held until downstream accepts
    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_CLEAR = CLEAR;
    localparam logic [2:0] ST_FEED  = FEED;
    localparam logic [2:0] ST_DRAIN = DRAIN;
    localparam logic [2:0] ST_DONE  = DONE;

    localparam int             DRN_W      = cnt_w(DRAIN_CYCLES);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [1:0]     FEED_LAST  = 2'(FEED_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       feed_cnt_q, feed_cnt_d;
    logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             latch, capture, abort_hit;

    logic [DATA_W-1:0] a00_q, a01_q, a10_q, a11_q;
    logic [DATA_W-1:0] b00_q, b01_q, b10_q, b11_q;
    logic [ACC_W-1:0]  c00_q, c01_q, c10_q, c11_q;

    logic              in_ready_q, busy_q, out_valid_q, acc_clr_q, feed_valid_q;
    logic [DATA_W-1:0] a_row0_q, a_row1_q, b_col0_q, b_col1_q;
    logic [DATA_W-1:0] a_row0_d, a_row1_d, b_col0_d, b_col1_d;

    always_comb begin
        state_d     = state_q;
        feed_cnt_d  = feed_cnt_q;
        drain_cnt_d = drain_cnt_q;
        latch       = 1'b0;
        capture     = 1'b0;
        abort_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    latch   = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    feed_cnt_d = '0;
                    state_d    = ST_FEED;
                end
            end
            ST_FEED: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else if (feed_cnt_q == FEED_LAST) begin
                    drain_cnt_d = DRAIN_LOAD;
                    state_d     = ST_DRAIN;
                end else begin
                    feed_cnt_d = feed_cnt_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else if (drain_cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Feed buses are computed from the next step so they leave a flop aligned with it.
    systolic_skew_feed #(.DATA_W(DATA_W)) u_skew (
        .active_i (state_d == ST_FEED),
        .cnt_i    (feed_cnt_d),
        .a00_i    (a00_q),
        .a01_i    (a01_q),
        .a10_i    (a10_q),
        .a11_i    (a11_q),
        .b00_i    (b00_q),
        .b01_i    (b01_q),
        .b10_i    (b10_q),
        .b11_i    (b11_q),
        .a_row0_o (a_row0_d),
        .a_row1_o (a_row1_d),
        .b_col0_o (b_col0_d),
        .b_col1_o (b_col1_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            feed_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            acc_clr_q    <= 1'b0;
            feed_valid_q <= 1'b0;
            a_row0_q     <= '0;
            a_row1_q     <= '0;
            b_col0_q     <= '0;
            b_col1_q     <= '0;
        end else begin
            state_q      <= state_d;
            feed_cnt_q   <= feed_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            in_ready_q   <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            out_valid_q  <= (state_d == ST_DONE);
            acc_clr_q    <= (state_d == ST_CLEAR) || abort_hit;
            feed_valid_q <= (state_d == ST_FEED);
            a_row0_q     <= a_row0_d;
            a_row1_q     <= a_row1_d;
            b_col0_q     <= b_col0_d;
            b_col1_q     <= b_col1_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a00_q <= '0; a01_q <= '0; a10_q <= '0; a11_q <= '0;
            b00_q <= '0; b01_q <= '0; b10_q <= '0; b11_q <= '0;
        end else if (latch) begin
            a00_q <= a00; a01_q <= a01; a10_q <= a10; a11_q <= a11;
            b00_q <= b00; b01_q <= b01; b10_q <= b10; b11_q <= b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c00_q <= '0; c01_q <= '0; c10_q <= '0; c11_q <= '0;
        end else if (capture) begin
            c00_q <= acc00; c01_q <= acc01; c10_q <= acc10; c11_q <= acc11;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign acc_clr    = acc_clr_q;
    assign feed_valid = feed_valid_q;
    assign a_row0     = a_row0_q;
    assign a_row1     = a_row1_q;
    assign b_col0     = b_col0_q;
    assign b_col1     = b_col1_q;
    assign c00        = c00_q;
    assign c01        = c01_q;
    assign c10        = c10_q;
    assign c11        = c11_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a behavioural 2x2 PE grid on the feed buses.
module tb_systolic_ctrl;

    logic        clk, rst;
    logic        in_valid, in_ready, abort, acc_clr, feed_valid;
    logic [7:0]  a00, a01, a10, a11, b00, b01, b10, b11;
    logic [7:0]  a_row0, a_row1, b_col0, b_col1;
    logic [15:0] acc00, acc01, acc10, acc11;
    logic [15:0] c00, c01, c10, c11;
    logic        out_valid, out_ready, busy;

    int tests = 0;
    int fails = 0;
    logic [31:0] feed_exp [3];
    logic [63:0] c_prev;

    systolic_ctrl #(.DATA_W(8), .ACC_W(16), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a00(a00), .a01(a01), .a10(a10), .a11(a11),
        .b00(b00), .b01(b01), .b10(b10), .b11(b11),
        .abort(abort), .acc_clr(acc_clr), .feed_valid(feed_valid),
        .a_row0(a_row0), .a_row1(a_row1), .b_col0(b_col0), .b_col1(b_col1),
        .acc00(acc00), .acc01(acc01), .acc10(acc10), .acc11(acc11),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-stationary PE grid: A moves right, B moves down, one register per hop.
    logic [7:0] pa00_q, pb00_q, pa10_q, pb01_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pa00_q <= '0; pb00_q <= '0; pa10_q <= '0; pb01_q <= '0;
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
        end else begin
            pa00_q <= a_row0;
            pb00_q <= b_col0;
            pa10_q <= a_row1;
            pb01_q <= b_col1;
            if (acc_clr) begin
                acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
            end else begin
                acc00 <= acc00 + 16'(a_row0) * 16'(b_col0);
                acc01 <= acc01 + 16'(pa00_q) * 16'(b_col1);
                acc10 <= acc10 + 16'(a_row1) * 16'(pb00_q);
                acc11 <= acc11 + 16'(pa10_q) * 16'(pb01_q);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] xa00, xa01, xa10, xa11, xb00, xb01, xb10, xb11);
        a00 = xa00; a01 = xa01; a10 = xa10; a11 = xa11;
        b00 = xb00; b01 = xb01; b10 = xb10; b11 = xb11;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        feed_exp[0] = {8'd1, 8'd0, 8'd5, 8'd0};
        feed_exp[1] = {8'd2, 8'd3, 8'd7, 8'd6};
        feed_exp[2] = {8'd0, 8'd4, 8'd0, 8'd8};
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        #22;
        check("rst_in_ready", in_ready, 1);
        check("rst_flags", {busy, out_valid, acc_clr, feed_valid}, 0);
        check("rst_feed", {a_row0, a_row1, b_col0, b_col1}, 0);
        check("rst_c", {c00, c01, c10, c11}, 0);
        rst = 1'b0;
        tick;

        // job 1: trace, stray in_valid during FEED, backpressure
        load(1, 2, 3, 4, 5, 6, 7, 8);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        load(9, 9, 9, 9, 9, 9, 9, 9);
        check("c1_acc_clr", acc_clr, 1);
        check("c1_busy_ready_fv", {busy, in_ready, feed_valid}, 3'b100);
        tick;
        for (int t = 0; t < 3; t++) begin
            check($sformatf("feed_t%0d", t), {a_row0, a_row1, b_col0, b_col1}, feed_exp[t]);
            check($sformatf("feed_t%0d_flags", t), {feed_valid, acc_clr, in_ready}, 3'b100);
            in_valid = (t == 1);
            tick;
        end
        in_valid = 1'b0;
        check("c5_drain", {feed_valid, out_valid, busy}, 3'b001);
        check("c5_feed_zero", {a_row0, a_row1, b_col0, b_col1}, 0);
        tick;
        check("c6_no_valid", out_valid, 0);
        out_ready = 1'b0;
        tick;
        check("c7_out_valid", out_valid, 1);
        check("c7_result", {c00, c01, c10, c11}, {16'd19, 16'd22, 16'd43, 16'd50});
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d", i), {out_valid, in_ready, c00, c01, c10, c11},
                  {1'b1, 1'b0, 16'd19, 16'd22, 16'd43, 16'd50});
            tick;
        end
        out_ready = 1'b1;
        check("bp_release_valid", out_valid, 1);
        tick;
        check("bp_after_accept", {in_ready, out_valid, busy}, 3'b100);
        check("bp_c_held", {c00, c01, c10, c11}, {16'd19, 16'd22, 16'd43, 16'd50});

        // job 2: abort in FEED step 1 (cycle 3)
        load(2, 3, 4, 5, 6, 7, 8, 9);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_idle", {busy, in_ready, feed_valid, out_valid}, 4'b0100);
        check("abort_clr", acc_clr, 1);
        check("abort_c_kept", {c00, c01, c10, c11}, {16'd19, 16'd22, 16'd43, 16'd50});
        for (int i = 0; i < 4; i++) begin
            tick;
            check($sformatf("abort_quiet%0d", i), {out_valid, acc_clr, busy}, 0);
        end

        // job 3 followed back-to-back by job 4
        load(3, 1, 2, 5, 4, 2, 1, 6);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (6) tick;
        check("j3_valid", out_valid, 1);
        check("j3_result", {c00, c01, c10, c11}, {16'd13, 16'd12, 16'd13, 16'd34});
        tick;
        check("j3_ready_next", {in_ready, out_valid}, 2'b10);
        load(255, 255, 255, 255, 255, 255, 255, 255);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("j4_accept_clr", acc_clr, 1);
        repeat (6) tick;
        check("j4_wrap", {out_valid, c00, c01, c10, c11},
              {1'b1, 16'd64514, 16'd64514, 16'd64514, 16'd64514});
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("done_abort_ignored", {out_valid, acc_clr, busy}, 3'b101);
        out_ready = 1'b1;
        tick;
        check("j4_released", in_ready, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("idle_abort_ignored", {acc_clr, busy, in_ready}, 3'b001);

        // job 5: abort coincides with the capture edge
        load(1, 2, 3, 4, 5, 6, 7, 8);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("cap_abort_flags", {out_valid, busy, acc_clr}, 3'b001);
        c_prev = {16'd64514, 16'd64514, 16'd64514, 16'd64514};
        check("cap_abort_c", {c00, c01, c10, c11}, c_prev);
        tick;
        check("cap_abort_quiet", out_valid, 0);

        // job 6: async reset mid-DRAIN, then a clean job
        load(3, 1, 2, 5, 4, 2, 1, 6);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_flags", {in_ready, busy, out_valid, acc_clr, feed_valid}, 5'b10000);
        check("mid_rst_c", {c00, c01, c10, c11}, 0);
        #3 rst = 1'b0;
        tick;
        load(1, 2, 3, 4, 5, 6, 7, 8);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (6) tick;
        check("post_rst_result", {out_valid, c00, c01, c10, c11},
              {1'b1, 16'd19, 16'd22, 16'd43, 16'd50});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
